// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage register with a 2-entry skid buffer.
// Carries NCH channels of WIDTH bits as one entry, valid/ready handshake on both
// sides. in_ready depends only on registered state, so downstream stalls never
// chain combinationally into upstream stages. flush kills both entries.
// Optional perf counters (stall_cnt, bubble_cnt) are enabled by defining
// PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bubble_cnt
`endif
);

  localparam int BW = NCH * WIDTH;

  // EMPTY: no entry; BUSY: main entry only; FULL: main and skid entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   main_data_q, main_data_d;
  logic [BW-1:0]   skid_data_q, skid_data_d;

  // Ready and valid are pure functions of the registered state.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  // main_data_q is zeroed whenever the main entry empties, so a bubble reads as NOP.
  assign out_data  = main_data_q;

  // Next-state and entry movement for the handshake, with flush overriding it.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid) begin
            state_d     = BUSY;
            main_data_d = in_data;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            main_data_d = in_data;
          end else if (in_valid) begin
            state_d     = FULL;
            skid_data_d = in_data;
          end else if (out_ready) begin
            state_d     = EMPTY;
            main_data_d = '0;
          end
        end
        FULL: begin
          // in_ready is low here, so in_valid is ignored.
          if (out_ready) begin
            state_d     = BUSY;
            main_data_d = skid_data_q;
            skid_data_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = '0;
          skid_data_d = '0;
        end
      endcase
    end
  end

  // State and entry registers; reset dominates flush and handshake.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (Rst) begin
      state_q     <= EMPTY;
      // NOTE: the data entries are reset too, because out_data must read zero
      // (NOP) right after reset rather than whatever was left in the flops.
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  // Saturating counts of stalled and empty cycles; flush does not touch them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, random
// stimulus against a queue-based reference model, and perf-counter sequences
// when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int BW    = WIDTH * NCH;

  logic          Clk;
  logic          Rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  pipe_stage_skid #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Same 32-bit value in every channel.
  function automatic logic [BW-1:0] rep(input logic [31:0] v);
    logic [BW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic        eir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic rst, input logic fl, input logic iv, input logic ordy,
                               input logic [31:0] d, input logic ev, input logic [31:0] ed,
                               input logic eir);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy;
    v.d = d; v.ev = ev; v.ed = ed; v.eir = eir;
    return v;
  endfunction

  // Reference model: the stage is a FIFO of at most two whole entries.
  logic [BW-1:0] mq[$];
  logic [31:0]   m_stall;
  logic [31:0]   m_bubble;

  task automatic model_edge(input logic rst, input logic fl, input logic iv, input logic ordy,
                            input logic [BW-1:0] d);
    logic ov, ir;
    ov = (mq.size() != 0);
    ir = (mq.size() < 2);
    if (rst) begin
      mq.delete();
      m_stall  = '0;
      m_bubble = '0;
    end else begin
      if (ov && !ordy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (!ov && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 1;
      if (fl) mq.delete();
      else begin
        if (ov && ordy) void'(mq.pop_front());
        if (iv && ir) mq.push_back(d);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic [BW-1:0] d);
    Rst = rst; flush = fl; in_valid = iv; out_ready = ordy; in_data = d;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Reset with garbage offered.
    tbl.push_back(mkv(1, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h0, 0, 0, 1));
    // Streaming at full rate.
    tbl.push_back(mkv(0, 0, 1, 1, 32'h1, 1, 32'h1, 1));
    tbl.push_back(mkv(0, 0, 1, 1, 32'h2, 1, 32'h2, 1));
    tbl.push_back(mkv(0, 0, 1, 1, 32'h3, 1, 32'h3, 1));
    tbl.push_back(mkv(0, 0, 1, 1, 32'h4, 1, 32'h4, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h0, 0, 0, 1));
    // Backpressure into the skid entry, then drain in order.
    tbl.push_back(mkv(0, 0, 1, 1, 32'hA, 1, 32'hA, 1));
    tbl.push_back(mkv(0, 0, 1, 0, 32'hB, 1, 32'hA, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 32'hC, 1, 32'hA, 0));
    tbl.push_back(mkv(0, 0, 1, 1, 32'hC, 1, 32'hB, 1));
    tbl.push_back(mkv(0, 0, 1, 1, 32'hC, 1, 32'hC, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h0, 0, 0, 1));
    // Flush while FULL discards both entries and the offered word.
    tbl.push_back(mkv(0, 0, 1, 1, 32'hA, 1, 32'hA, 1));
    tbl.push_back(mkv(0, 0, 1, 0, 32'hB, 1, 32'hA, 0));
    tbl.push_back(mkv(0, 1, 1, 0, 32'hD, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h0, 0, 0, 1));
    // Flush while EMPTY drops data even though in_ready is high.
    tbl.push_back(mkv(0, 1, 1, 1, 32'hE, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h0, 0, 0, 1));
    // Rst and flush together while BUSY.
    tbl.push_back(mkv(0, 0, 1, 0, 32'h5, 1, 32'h5, 1));
    tbl.push_back(mkv(1, 1, 1, 0, 32'h6, 0, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, rep(tbl[i].d));
      @(posedge Clk);
      #1;
      check($sformatf("tbl%0d_out_valid", i), BW'(out_valid), BW'(tbl[i].ev));
      check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ev ? rep(tbl[i].ed) : '0);
      check($sformatf("tbl%0d_in_ready", i), BW'(in_ready), BW'(tbl[i].eir));
    end
`ifdef PIPE_STAGE_PERF_EN
    check("rst_flush_stall_cnt", BW'(stall_cnt), '0);
    check("rst_flush_bubble_cnt", BW'(bubble_cnt), '0);
`endif

    // Random stimulus against the FIFO model; first cycle is a reset.
    for (int c = 0; c < 3000; c++) begin
      logic          r_rst, r_fl, r_iv, r_or;
      logic [BW-1:0] r_d;
      r_rst = (c == 0) || ($urandom_range(0, 99) == 0);
      r_fl  = ($urandom_range(0, 19) == 0);
      r_iv  = ($urandom_range(0, 3) != 0);
      r_or  = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < NCH; k++) r_d[k*WIDTH +: WIDTH] = $urandom;
      drive(r_rst, r_fl, r_iv, r_or, r_d);
      model_edge(r_rst, r_fl, r_iv, r_or, r_d);
      @(posedge Clk);
      #1;
      check("rnd_out_valid", BW'(out_valid), BW'(mq.size() != 0));
      check("rnd_out_data", out_data, (mq.size() != 0) ? mq[0] : '0);
      check("rnd_in_ready", BW'(in_ready), BW'(mq.size() < 2));
`ifdef PIPE_STAGE_PERF_EN
      check("rnd_stall_cnt", BW'(stall_cnt), BW'(m_stall));
      check("rnd_bubble_cnt", BW'(bubble_cnt), BW'(m_bubble));
`endif
    end

`ifdef PIPE_STAGE_PERF_EN
    // 3 idle cycles, 1 accepting cycle, 5 stalled cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(posedge Clk); #1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge Clk); #1;
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, rep(32'h77));
    @(posedge Clk); #1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge Clk); #1;
    end
    check("perf_bubble_cnt", BW'(bubble_cnt), BW'(32'd4));
    check("perf_stall_cnt", BW'(stall_cnt), BW'(32'd5));
    // A flush during a stalled cycle still counts it and clears nothing.
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    @(posedge Clk); #1;
    check("flush_keep_stall_cnt", BW'(stall_cnt), BW'(32'd6));
    check("flush_keep_bubble_cnt", BW'(bubble_cnt), BW'(32'd4));
    check("flush_out_valid", BW'(out_valid), '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
